fdam_dsm_reporter: RTL and testbench
====================================

Name: fdam_dsm_reporter

Overview:
- Next-generation device-status-memory (DSM) writer for one accelerator.
- Keeps a per-queue transfer counter for every input and output queue, snapshots those counters together with the done flags, and writes them as cache lines to a host DSM region through the shared write arbiter.
- Over the fixed 16-per-line generation it adds: slots-per-line derived from DATA_WIDTH/QTD_WIDTH, periodic and forced updates, a coalesced pending trigger, an atomic snapshot, a sequence number, and a valid/ready write handshake.

Parameters:
- ACC_ID, 1, accelerator id; used for conf match and write tag.
- ADDR_WIDTH, 48, cache-line address width.
- QTD_WIDTH, 32, counter and slot width; DATA_WIDTH must be a multiple of it.
- TAG_WIDTH, 16, write tag width.
- CONF_ID_QUEUE_WIDTH, 32, conf id field width.
- PERIOD_WIDTH, 24, width of the periodic-update interval.
- DATA_WIDTH, 512, line width; must be at least NUM_INPUT_QUEUES+NUM_OUTPUT_QUEUES+33.
- NUM_INPUT_QUEUES, 1, number of read queues, at least 1.
- NUM_OUTPUT_QUEUES, 1, number of write queues, at least 1.
- DELAY_CYCLES, 512, settle delay between trigger and snapshot, at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  enable; while 0 the FSM, triggers and period timer hold.
- conf_valid  in  2  01 = configure, 10 = soft reset, others ignored.
- conf  in  ADDR_WIDTH+PERIOD_WIDTH+CONF_ID_QUEUE_WIDTH  {addr_base, period, id}, id in LSBs.
- done_rd  in  NUM_INPUT_QUEUES  per-queue read done.
- done_wr  in  NUM_OUTPUT_QUEUES  per-queue write done.
- done_acc  in  1  accelerator done.
- acc_req_rd_data_en  in  NUM_INPUT_QUEUES  per-queue read beat strobe.
- acc_req_wr_data_en  in  NUM_OUTPUT_QUEUES  per-queue write beat strobe.
- force_update  in  1  one-cycle software/debug trigger.
- write_ready  in  1  arbiter accepts the current line.
- write_valid  out  1  line presented.
- write_data  out  DATA_WIDTH+ADDR_WIDTH+TAG_WIDTH  {line, addr, tag}; tag = {1'b1, ACC_ID[TAG_WIDTH-2:0]}.
- write_resp_valid  in  1  write completion.
- write_resp_tag  in  TAG_WIDTH  completion tag.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: rst, or conf_valid==10 with id==ACC_ID, clears all state. Outputs after reset: write_valid=0, busy=0, write_data=0. Internal state cleared: counters, snapshot, seq, done_last, pending, timer, conf_ready, addr_base, period.
- Configure: conf_valid==01 with id==ACC_ID latches addr_base and period and sets conf_ready. Reconfiguring while busy takes effect on the next update; the current update keeps its latched base.
- Counters: QTD_WIDTH bits, +1 per strobe cycle, wrap at 2^QTD_WIDTH, never cleared except by reset.
- Layout constants:
  - S = DATA_WIDTH/QTD_WIDTH.
  - LR = ceil(NI/S), LW = ceil(NO/S).
  - L = align4(LR+LW+1).
- Line order at addr_base+k:
  - Read-counter lines first; slot j of line k = queue k*S+j at bits [j*QTD_WIDTH +: QTD_WIDTH]; nonexistent slots = 0.
  - Then write-counter lines, same packing.
  - Then zero pad lines.
  - Line L-1 is the status line: bit DATA_WIDTH-1 = done_acc; bits [DATA_WIDTH-2 -: 32] = seq; then {done_wr, done_rd} in LSBs; rest 0.
- Triggers are registered one cycle and OR-ed; each sets pending:
  - rising edge of any bit of {done_acc, done_wr, done_rd} relative to done_last;
  - period timer reaching period (period!=0; timer reloads to 0 on reaching it);
  - force_update.
- FSM:
  - IDLE: if pending and conf_ready, clear pending, go DELAY.
  - DELAY: count DELAY_CYCLES cycles, then go SNAP.
  - SNAP: one cycle. Copy all counters and done flags to the snapshot; done_last <= done; seq <= seq+1 (the status line carries the new seq); idx <= 0; go WRITE.
  - WRITE: write_valid=1 with line idx from the snapshot. On write_valid&&write_ready, idx+1. After accepting idx==L-1, go WAIT.
  - WAIT: resp_count increments on write_resp_valid with a matching tag; when resp_count==L, clear it and go IDLE.
- Handshake rules:
  - write_valid and write_data stay stable until accepted.
  - write_data never changes while write_valid=1.
- Simultaneous events and coalescing:
  - Triggers arriving while busy set pending; any number coalesce into exactly one further update.
  - A trigger in the same cycle as the IDLE exit is kept pending.
- Counters keep counting during an update; the snapshot does not change.
- Responses outside WAIT count toward resp_count (a fast arbiter may answer early); resp_count saturates at L.
- start=0 freezes the FSM, timer and trigger capture. Counters still count. A held line stays presented.

Decomposition:
- Package fdam_dsm_pkg holds:
  - FSM state encoding;
  - conf_valid codes;
  - S/LR/LW/L computation functions;
  - tag construction function;
  - status-line field offsets.
- One sub-module, fdam_dsm_counter_bank: a parametrised array of per-queue counters with a flattened output bus; instantiated twice (read, write).

Test Plan:
- Baseline update:
  - Stimulus: NI=NO=1, configure addr_base=0x100, period=0; 5 read strobes, 3 write strobes, pulse done_acc.
  - Response: 4 lines at 0x100-0x103 after 512+2 cycles; line0 slot0=5, line1 slot0=3, line2=0, line3 bit511=1 with seq=1; busy falls after 4 responses.
- Multi-line packing:
  - Stimulus: NI=20, NO=1, QTD_WIDTH=32; strobe queue 17 seven times.
  - Response: line1 bits[63:32]=7; L=4; write-counter line at index 2.
- Backpressure:
  - Stimulus: write_ready toggles 1-0-0-1 during WRITE.
  - Response: write_data stable while stalled; exactly L lines accepted; no duplicates.
- Coalesced triggers:
  - Stimulus: force_update three times during DELAY.
  - Response: exactly one extra update; seq goes 1 then 2; second status line reflects the later counters.
- Periodic:
  - Stimulus: period=1000, no done edges.
  - Response: an update starts every 1000 start-cycles; period=0 yields no updates.
- Soft reset mid-WRITE:
  - Stimulus: conf_valid=10 with id=ACC_ID after 2 lines accepted.
  - Response: next cycle write_valid=0, busy=0, counters=0, seq=0; no update until reconfigured.

Source files
------------

// File: rtl/fdam_dsm_pkg.sv
// Shared types, codes and layout helpers for the DSM reporter.
// Pure declarations; no latency and no flow control.
// Layout helpers assume DATA_WIDTH is a multiple of QTD_WIDTH.
package fdam_dsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_SNAP,
        ST_WRITE,
        ST_WAIT
    } dsm_state_t;

    localparam logic [1:0] CONF_CFG  = 2'b01;
    localparam logic [1:0] CONF_SRST = 2'b10;

    // Status line: done_acc in the MSB, seq just below it, done flags in the LSBs.
    localparam int SEQ_W = 32;

    function automatic int dsm_slots(input int dw, input int qw);
        return dw / qw;
    endfunction

    function automatic int dsm_ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int dsm_lines(input int ni, input int no, input int s);
        int n;
        n = dsm_ceil_div(ni, s) + dsm_ceil_div(no, s) + 1;
        return ((n + 3) / 4) * 4;
    endfunction

    function automatic logic [31:0] dsm_tag(input int tw, input int id);
        logic [31:0] msb;
        msb = 32'd1 << (tw - 1);
        return msb | (32'(id) & (msb - 32'd1));
    endfunction

endpackage

// File: rtl/fdam_dsm_counter_bank.sv
// Array of free-running per-queue beat counters, flattened output bus.
// Latency: count visible one cycle after the strobe.
// No backpressure; counters wrap at 2^W.
module fdam_dsm_counter_bank #(
    parameter int N = 1,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] en,
    output logic [N*W-1:0] cnt
);

    for (genvar i = 0; i < N; i++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (clr)
                cnt[i*W +: W] <= '0;
            else if (en[i])
                cnt[i*W +: W] <= cnt[i*W +: W] + W'(1);
        end
    end

endmodule

// File: rtl/fdam_dsm_reporter.sv
// Snapshots per-queue counters and done flags and writes them as DSM lines to the host.
// Latency: trigger -> first line ~DELAY_CYCLES+4 cycles; L lines then L responses.
// Backpressure: write_valid/write_data held until write_ready; triggers coalesce into pending.
module fdam_dsm_reporter
    import fdam_dsm_pkg::*;
#(
    parameter int ACC_ID              = 1,
    parameter int ADDR_WIDTH          = 48,
    parameter int QTD_WIDTH           = 32,
    parameter int TAG_WIDTH           = 16,
    parameter int CONF_ID_QUEUE_WIDTH = 32,
    parameter int PERIOD_WIDTH        = 24,
    parameter int DATA_WIDTH          = 512,
    parameter int NUM_INPUT_QUEUES    = 1,
    parameter int NUM_OUTPUT_QUEUES   = 1,
    parameter int DELAY_CYCLES        = 512
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic [1:0] conf_valid,
    input  logic [ADDR_WIDTH+PERIOD_WIDTH+CONF_ID_QUEUE_WIDTH-1:0] conf,
    input  logic [NUM_INPUT_QUEUES-1:0] done_rd,
    input  logic [NUM_OUTPUT_QUEUES-1:0] done_wr,
    input  logic done_acc,
    input  logic [NUM_INPUT_QUEUES-1:0] acc_req_rd_data_en,
    input  logic [NUM_OUTPUT_QUEUES-1:0] acc_req_wr_data_en,
    input  logic force_update,
    input  logic write_ready,
    output logic write_valid,
    output logic [DATA_WIDTH+ADDR_WIDTH+TAG_WIDTH-1:0] write_data,
    input  logic write_resp_valid,
    input  logic [TAG_WIDTH-1:0] write_resp_tag,
    output logic busy
);

    localparam int NI      = NUM_INPUT_QUEUES;
    localparam int NO      = NUM_OUTPUT_QUEUES;
    localparam int DW      = DATA_WIDTH;
    localparam int QW      = QTD_WIDTH;
    localparam int S       = dsm_slots(DW, QW);
    localparam int LR      = dsm_ceil_div(NI, S);
    localparam int LW      = dsm_ceil_div(NO, S);
    localparam int L       = dsm_lines(NI, NO, S);
    localparam int NT      = NI + NO + 1;
    localparam int IDX_W   = $clog2(L);
    localparam int RC_W    = $clog2(L + 1);
    localparam int DLY_W   = $clog2(DELAY_CYCLES + 1);
    localparam int SEQ_LSB = DW - 1 - SEQ_W;
    localparam int IDW     = CONF_ID_QUEUE_WIDTH;
    localparam logic [31:0] TAG32 = dsm_tag(TAG_WIDTH, ACC_ID);
    localparam logic [TAG_WIDTH-1:0] TAG = TAG32[TAG_WIDTH-1:0];

    logic id_hit, soft_rst, cfg_hit, clr;
    logic [NI*QW-1:0] cnt_rd, snap_rd;
    logic [NO*QW-1:0] cnt_wr, snap_wr;
    logic [LR*DW-1:0] rd_pad;
    logic [LW*DW-1:0] wr_pad;
    logic [NT-1:0] done_vec, done_last, done_q, snap_done;
    logic [SEQ_W-1:0] seq;
    logic pending, trig_q, conf_ready, done_rise, period_hit;
    logic [ADDR_WIDTH-1:0] addr_base, cur_base;
    logic [PERIOD_WIDTH-1:0] period, timer, timer_nxt;
    dsm_state_t state;
    logic [IDX_W-1:0] idx;
    logic [DLY_W-1:0] dly_cnt;
    logic [RC_W-1:0] resp_count;
    logic [DW-1:0] line, status;

    assign id_hit   = conf[IDW-1:0] == IDW'(ACC_ID);
    assign soft_rst = (conf_valid == CONF_SRST) && id_hit;
    assign cfg_hit  = (conf_valid == CONF_CFG) && id_hit;
    assign clr      = rst || soft_rst;

    fdam_dsm_counter_bank #(.N(NI), .W(QW)) u_cnt_rd (
        .clk (clk),
        .clr (clr),
        .en  (acc_req_rd_data_en),
        .cnt (cnt_rd)
    );

    fdam_dsm_counter_bank #(.N(NO), .W(QW)) u_cnt_wr (
        .clk (clk),
        .clr (clr),
        .en  (acc_req_wr_data_en),
        .cnt (cnt_wr)
    );

    assign done_vec = {done_acc, done_wr, done_rd};
    // Fire once per rising edge, and only for flags not already reported.
    assign done_rise  = |(done_vec & ~done_last & ~done_q);
    assign timer_nxt  = timer + PERIOD_WIDTH'(1);
    assign period_hit = (period != '0) && (timer_nxt >= period);

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= ST_IDLE;
            write_valid <= 1'b0;
            snap_rd     <= '0;
            snap_wr     <= '0;
            snap_done   <= '0;
            done_last   <= '0;
            done_q      <= '0;
            seq         <= '0;
            pending     <= 1'b0;
            trig_q      <= 1'b0;
            timer       <= '0;
            conf_ready  <= 1'b0;
            addr_base   <= '0;
            cur_base    <= '0;
            period      <= '0;
            idx         <= '0;
            dly_cnt     <= '0;
            resp_count  <= '0;
        end else begin
            if (cfg_hit) begin
                addr_base  <= conf[IDW+PERIOD_WIDTH +: ADDR_WIDTH];
                period     <= conf[IDW +: PERIOD_WIDTH];
                conf_ready <= 1'b1;
            end
            if (write_resp_valid && (write_resp_tag == TAG) && (resp_count != RC_W'(L)))
                resp_count <= resp_count + RC_W'(1);
            if (start) begin
                done_q  <= done_vec;
                trig_q  <= done_rise || period_hit || force_update;
                timer   <= (period == '0 || period_hit) ? '0 : timer_nxt;
                pending <= pending || trig_q;
                case (state)
                    ST_IDLE: if (pending && conf_ready) begin
                        pending  <= trig_q;
                        cur_base <= addr_base;
                        dly_cnt  <= '0;
                        state    <= ST_DELAY;
                    end
                    ST_DELAY: begin
                        if (dly_cnt == DLY_W'(DELAY_CYCLES - 1))
                            state <= ST_SNAP;
                        else
                            dly_cnt <= dly_cnt + DLY_W'(1);
                    end
                    ST_SNAP: begin
                        snap_rd     <= cnt_rd;
                        snap_wr     <= cnt_wr;
                        snap_done   <= done_vec;
                        done_last   <= done_vec;
                        seq         <= seq + SEQ_W'(1);
                        idx         <= '0;
                        write_valid <= 1'b1;
                        state       <= ST_WRITE;
                    end
                    ST_WAIT: if (resp_count == RC_W'(L)) begin
                        resp_count <= '0;
                        state      <= ST_IDLE;
                    end
                    default: ;
                endcase
            end
            // An offered line cannot be withdrawn, so acceptance advances even while start is low.
            if (state == ST_WRITE && write_valid && write_ready) begin
                if (idx == IDX_W'(L - 1)) begin
                    write_valid <= 1'b0;
                    state       <= ST_WAIT;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    assign rd_pad = (LR*DW)'(snap_rd);
    assign wr_pad = (LW*DW)'(snap_wr);

    always_comb begin
        status = '0;
        status[DW-1] = snap_done[NT-1];
        status[SEQ_LSB +: SEQ_W] = seq;
        status[NI+NO-1:0] = snap_done[NI+NO-1:0];
    end

    always_comb begin
        line = '0;
        for (int k = 0; k < LR; k++)
            if (idx == IDX_W'(k)) line = rd_pad[k*DW +: DW];
        for (int k = 0; k < LW; k++)
            if (idx == IDX_W'(LR + k)) line = wr_pad[k*DW +: DW];
        if (idx == IDX_W'(L - 1)) line = status;
    end

    assign write_data = write_valid ? {line, cur_base + ADDR_WIDTH'(idx), TAG} : '0;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_fdam_dsm_reporter.sv
// Directed bench: single-queue and 20-read-queue reporters in lockstep, scoreboarded lines.
module tb_fdam_dsm_reporter;

    localparam int DW  = 512;
    localparam int AW  = 48;
    localparam int TW  = 16;
    localparam int WDW = DW + AW + TW;
    localparam int NIB = 20;

    logic clk = 1'b0;
    logic rst, start, done_acc, force_update, write_ready, write_resp_valid;
    logic [1:0] conf_valid;
    logic [AW+24+32-1:0] conf;
    logic [TW-1:0] write_resp_tag;
    logic [0:0] a_done_rd, done_wr, a_rd_en, wr_en;
    logic [NIB-1:0] b_done_rd, b_rd_en;
    logic a_wv, b_wv, a_busy, b_busy;
    logic [WDW-1:0] a_wd, b_wd;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int acc_a = 0;
    int owed = 0;
    int upd_starts = 0;
    int start_cyc = 0;
    bit resp_en = 1'b1;
    bit bp = 1'b0;

    logic [WDW-1:0] qa[$];
    logic [WDW-1:0] qb[$];

    int unsigned m_a_rd = 0, m_wr = 0, m_seq = 0;
    int unsigned m_b_rd[NIB];
    logic m_acc = 1'b0;
    logic [AW-1:0] m_base = '0;

    fdam_dsm_reporter #(.ACC_ID(1), .NUM_INPUT_QUEUES(1), .NUM_OUTPUT_QUEUES(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .conf_valid(conf_valid), .conf(conf),
        .done_rd(a_done_rd), .done_wr(done_wr), .done_acc(done_acc),
        .acc_req_rd_data_en(a_rd_en), .acc_req_wr_data_en(wr_en),
        .force_update(force_update), .write_ready(write_ready),
        .write_valid(a_wv), .write_data(a_wd),
        .write_resp_valid(write_resp_valid), .write_resp_tag(write_resp_tag), .busy(a_busy)
    );

    fdam_dsm_reporter #(.ACC_ID(1), .NUM_INPUT_QUEUES(NIB), .NUM_OUTPUT_QUEUES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .conf_valid(conf_valid), .conf(conf),
        .done_rd(b_done_rd), .done_wr(done_wr), .done_acc(done_acc),
        .acc_req_rd_data_en(b_rd_en), .acc_req_wr_data_en(wr_en),
        .force_update(force_update), .write_ready(write_ready),
        .write_valid(b_wv), .write_data(b_wd),
        .write_resp_valid(write_resp_valid), .write_resp_tag(write_resp_tag), .busy(b_busy)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string tag, input logic [WDW-1:0] got, input logic [WDW-1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] status_line();
        logic [DW-1:0] ln;
        ln = '0;
        ln[DW-1] = m_acc;
        ln[DW-2 -: 32] = m_seq;
        return ln;
    endfunction

    function automatic logic [WDW-1:0] exp_a(input int k);
        logic [DW-1:0] ln;
        ln = '0;
        if (k == 0) ln[31:0] = m_a_rd;
        else if (k == 1) ln[31:0] = m_wr;
        else if (k == 3) ln = status_line();
        return {ln, m_base + AW'(k), 16'h8001};
    endfunction

    function automatic logic [WDW-1:0] exp_b(input int k);
        logic [DW-1:0] ln;
        ln = '0;
        if (k == 0) for (int q = 0; q < 16; q++) ln[q*32 +: 32] = m_b_rd[q];
        else if (k == 1) for (int q = 16; q < NIB; q++) ln[(q-16)*32 +: 32] = m_b_rd[q];
        else if (k == 2) ln[31:0] = m_wr;
        else ln = status_line();
        return {ln, m_base + AW'(k), 16'h8001};
    endfunction

    task automatic push_update();
        m_seq++;
        for (int k = 0; k < 4; k++) begin
            qa.push_back(exp_a(k));
            qb.push_back(exp_b(k));
        end
    endtask

    // Scoreboard monitor: compares accepted lines and holds, tracks update starts.
    initial begin
        logic a_stall, b_stall, prev_busy;
        logic [WDW-1:0] prev_a, prev_b;
        int n;
        a_stall = 0; b_stall = 0; prev_busy = 0; prev_a = '0; prev_b = '0;
        forever begin
            @(negedge clk);
            if (a_stall) begin chk("a hold valid", a_wv, 1); chk("a hold data", a_wd, prev_a); end
            if (b_stall) begin chk("b hold valid", b_wv, 1); chk("b hold data", b_wd, prev_b); end
            if (a_wv && write_ready) begin
                n = qa.size();
                chk("a line expected", n > 0, 1);
                if (n > 0) chk("a line", a_wd, qa.pop_front());
                acc_a++;
                owed++;
            end
            if (b_wv && write_ready) begin
                n = qb.size();
                chk("b line expected", n > 0, 1);
                if (n > 0) chk("b line", b_wd, qb.pop_front());
            end
            a_stall = a_wv && !write_ready;
            b_stall = b_wv && !write_ready;
            prev_a = a_wd;
            prev_b = b_wd;
            if (a_busy && !prev_busy) begin upd_starts++; start_cyc = cyc; end
            prev_busy = a_busy;
        end
    end

    initial begin
        int ph;
        logic [3:0] pat;
        ph = 0;
        pat = 4'b1001;
        write_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            write_ready = bp ? pat[3-ph] : 1'b1;
            ph = (ph + 1) % 4;
        end
    end

    initial begin
        write_resp_valid = 1'b0;
        write_resp_tag = 16'h8001;
        forever begin
            @(posedge clk); #1;
            if (resp_en && owed > 0) begin write_resp_valid = 1'b1; owed--; end
            else write_resp_valid = 1'b0;
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic cfg(input logic [AW-1:0] base, input logic [23:0] per);
        conf_valid = 2'b01;
        conf = {base, per, 32'd1};
        tick();
        conf_valid = 2'b00;
    endtask

    task automatic pulse_force();
        force_update = 1'b1;
        tick();
        force_update = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int lim);
        int i = 0;
        while (acc_a < n && i < lim) begin tick(); i++; end
        chk("accepted line count", acc_a >= n, 1);
    endtask

    task automatic wait_idle(input int lim);
        int i = 0;
        while (a_busy && i < lim) begin tick(); i++; end
        chk("returned to idle", a_busy, 0);
    endtask

    task automatic wait_starts(input int n, input int lim);
        int i = 0;
        while (upd_starts < n && i < lim) begin tick(); i++; end
        chk("update started", upd_starts >= n, 1);
    endtask

    initial begin
        int lat, a0, s0, t1, t2;
        rst = 1'b1; start = 1'b0; conf_valid = 2'b00; conf = '0;
        done_acc = 1'b0; force_update = 1'b0;
        a_done_rd = '0; done_wr = '0; b_done_rd = '0;
        a_rd_en = '0; wr_en = '0; b_rd_en = '0;
        for (int q = 0; q < NIB; q++) m_b_rd[q] = 0;
        repeat (3) tick();
        chk("reset a write_valid", a_wv, 0);
        chk("reset a busy", a_busy, 0);
        chk("reset a write_data", a_wd, '0);
        chk("reset b write_valid", b_wv, 0);
        chk("reset b busy", b_busy, 0);
        rst = 1'b0;
        start = 1'b1;

        // Baseline update with multi-line packing on the 20-queue instance.
        m_base = 48'h100;
        cfg(48'h100, 24'd0);
        for (int i = 0; i < 7; i++) begin
            a_rd_en = (i < 5);
            wr_en = (i < 3);
            b_rd_en = 20'h20000;
            tick();
        end
        a_rd_en = '0; wr_en = '0; b_rd_en = '0;
        m_a_rd = 5; m_wr = 3; m_b_rd[17] = 7;
        resp_en = 1'b0;
        done_acc = 1'b1;
        m_acc = 1'b1;
        push_update();
        lat = 0;
        while (!a_wv && lat < 600) begin tick(); lat++; end
        chk("baseline first-line latency window", (lat >= 514 && lat <= 518), 1);
        wait_acc(4, 100);
        repeat (5) tick();
        chk("waits for responses", a_busy, 1);
        resp_en = 1'b1;
        wait_idle(20);
        chk("baseline queue drained", qa.size() + qb.size(), 0);

        // Backpressure: ready pattern 1-0-0-1 while writing.
        bp = 1'b1;
        pulse_force();
        push_update();
        wait_acc(8, 1000);
        bp = 1'b0;
        wait_idle(50);
        chk("backpressure accepted lines", acc_a, 8);
        chk("backpressure queue drained", qa.size() + qb.size(), 0);

        // Coalesced triggers during DELAY, counters moving during WRITE.
        s0 = upd_starts;
        a0 = acc_a;
        pulse_force();
        push_update();
        wait_starts(s0 + 1, 20);
        repeat (20) tick();
        for (int i = 0; i < 3; i++) begin
            pulse_force();
            repeat (50) tick();
        end
        wait_acc(a0 + 1, 1000);
        for (int i = 0; i < 4; i++) begin
            a_rd_en = (i < 2);
            wr_en = 1'b1;
            b_rd_en = ((i < 1) ? 20'h00008 : 20'h0) | ((i < 2) ? 20'h80000 : 20'h0);
            tick();
        end
        a_rd_en = '0; wr_en = '0; b_rd_en = '0;
        m_a_rd += 2; m_wr += 4; m_b_rd[3] += 1; m_b_rd[19] += 2;
        push_update();
        wait_acc(a0 + 8, 2500);
        wait_idle(50);
        repeat (700) tick();
        chk("coalesced update count", upd_starts, s0 + 2);
        chk("coalesced queue drained", qa.size() + qb.size(), 0);

        // Periodic updates.
        s0 = upd_starts;
        cfg(48'h100, 24'd1000);
        wait_starts(s0 + 1, 1100);
        t1 = start_cyc;
        push_update();
        wait_idle(700);
        wait_starts(s0 + 2, 1100);
        t2 = start_cyc;
        push_update();
        chk("period interval", t2 - t1, 1000);
        wait_idle(700);
        cfg(48'h100, 24'd0);
        s0 = upd_starts;
        repeat (2500) tick();
        chk("period zero is silent", upd_starts, s0);
        chk("periodic queue drained", qa.size() + qb.size(), 0);

        // Soft reset after two accepted lines.
        done_acc = 1'b0;
        m_acc = 1'b0;
        repeat (3) tick();
        resp_en = 1'b0;
        a0 = acc_a;
        pulse_force();
        push_update();
        wait_acc(a0 + 2, 1000);
        conf_valid = 2'b10;
        conf = {48'h0, 24'h0, 32'd1};
        tick();
        conf_valid = 2'b00;
        chk("soft reset write_valid", a_wv, 0);
        chk("soft reset busy", a_busy, 0);
        chk("soft reset b busy", b_busy, 0);
        chk("soft reset write_data", a_wd, '0);
        qa.delete();
        qb.delete();
        owed = 0;
        resp_en = 1'b1;
        m_a_rd = 0; m_wr = 0; m_seq = 0;
        for (int q = 0; q < NIB; q++) m_b_rd[q] = 0;
        m_base = 48'h200;
        s0 = upd_starts;
        pulse_force();
        repeat (600) tick();
        chk("no update before reconfigure", upd_starts, s0);
        chk("no line before reconfigure", a_wv, 0);
        a0 = acc_a;
        push_update();
        cfg(48'h200, 24'd0);
        wait_acc(a0 + 4, 1000);
        wait_idle(50);
        chk("post-reset queue drained", qa.size() + qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
